// File: rtl/if_unit.sv
// Instruction fetch unit: single-outstanding request to instruction memory,
// one-entry output buffer toward decode, redirect handling with response discard.
module if_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [5:0]  id_op,
    output logic [5:0]  id_funct,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inflight_pc, inflight_pc_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_pc4, buf_pc4_nxt;
    logic        req_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            buf_valid   <= 1'b0;
            buf_instr   <= '0;
            buf_pc      <= '0;
            buf_pc4     <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight_pc <= inflight_pc_nxt;
            buf_valid   <= buf_valid_nxt;
            buf_instr   <= buf_instr_nxt;
            buf_pc      <= buf_pc_nxt;
            buf_pc4     <= buf_pc4_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inflight_pc_nxt = inflight_pc;
        buf_valid_nxt   = buf_valid;
        buf_instr_nxt   = buf_instr;
        buf_pc_nxt      = buf_pc;
        buf_pc4_nxt     = buf_pc4;

        // Gated by rst_n so no request is flagged while reset is held.
        imem_req_valid = rst_n && (state == ST_REQ) && !redirect_valid
                         && (!buf_valid || id_ready);
        imem_addr      = pc & 32'hFFFF_FFFC;
        req_fire       = imem_req_valid && imem_req_ready;

        if (buf_valid && id_ready)
            buf_valid_nxt = 1'b0;

        if (redirect_valid) begin
            pc_nxt        = redirect_pc & 32'hFFFF_FFFC;
            buf_valid_nxt = 1'b0;
            // An outstanding request must still be drained before refetching.
            if (state != ST_REQ)
                state_nxt = imem_rsp_valid ? ST_REQ : ST_DISCARD;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        inflight_pc_nxt = imem_addr;
                        state_nxt       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        buf_valid_nxt = 1'b1;
                        buf_instr_nxt = imem_rsp_data;
                        buf_pc_nxt    = inflight_pc;
                        buf_pc4_nxt   = inflight_pc + 32'd4;
                        pc_nxt        = inflight_pc + 32'd4;
                        state_nxt     = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rsp_valid)
                        state_nxt = ST_REQ;
                end
                default: state_nxt = ST_REQ;
            endcase
        end
    end

    assign id_valid    = buf_valid;
    assign id_instr    = buf_instr;
    assign id_op       = buf_instr[31:26];
    assign id_funct    = buf_instr[5:0];
    assign id_pc       = buf_pc;
    assign id_pc_plus4 = buf_pc4;

endmodule

// File: tb/tb_if_unit.sv
// Self-checking bench for if_unit: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level fetch model.
module tb_if_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;

    logic        imem_req_valid, id_valid;
    logic [31:0] imem_addr, id_instr, id_pc, id_pc_plus4;
    logic [5:0]  id_op, id_funct;

    logic        b_imem_req_valid, b_id_valid;
    logic [31:0] b_imem_addr, b_id_instr, b_id_pc, b_id_pc_plus4;
    logic [5:0]  b_id_op, b_id_funct;

    always #5 clk = ~clk;

    if_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_op(id_op), .id_funct(id_funct),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    if_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(b_imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(b_imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(b_id_valid), .id_ready(id_ready),
        .id_instr(b_id_instr), .id_op(b_id_op), .id_funct(b_id_funct),
        .id_pc(b_id_pc), .id_pc_plus4(b_id_pc_plus4)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_0020;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory environment
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int unsigned lat_lo = 1, lat_hi = 1, spur_pct = 0;

    // Reference model: fetch pointer, outstanding/stale request, decode buffer
    logic [31:0] m_pc, m_inflight, m_instr, m_bpc;
    bit          m_busy, m_stale, m_bv;

    // Observations of the most recent cycle
    logic        o_req, o_idv;
    logic [31:0] o_addr, o_pc, o_instr;
    logic [31:0] issued_q[$], b_issued_q[$], shown_q[$];
    bit          b_seen;
    logic [31:0] b_first_pc, b_first_pc4;

    task automatic model_reset();
        m_pc = 32'h0; m_inflight = '0; m_instr = '0; m_bpc = '0;
        m_busy = 0; m_stale = 0; m_bv = 0;
    endtask

    task automatic run_cycle(input bit rdy, input bit idr, input bit redir,
                             input logic [31:0] rpc, input bit frsp);
        bit rsp, exp_req, fire, dut_fire;
        imem_req_ready = rdy; id_ready = idr; redirect_valid = redir; redirect_pc = rpc;
        rsp = 0;
        imem_rsp_data = $urandom;
        if (mem_busy && mem_cnt == 0) begin
            rsp = 1;
            imem_rsp_data = mem_word(mem_addr);
        end else if (!mem_busy && (frsp || ($urandom_range(99) < spur_pct))) begin
            rsp = 1;
        end
        imem_rsp_valid = rsp;
        #1;
        o_req = imem_req_valid; o_addr = imem_addr; o_idv = id_valid;
        o_pc = id_pc; o_instr = id_instr;

        exp_req = !m_busy && !redir && (!m_bv || idr);
        check_val("req_valid", {31'b0, o_req}, {31'b0, exp_req});
        if (exp_req) check_val("imem_addr", o_addr, m_pc);
        check_val("id_valid", {31'b0, o_idv}, {31'b0, m_bv});
        if (m_bv) begin
            check_val("id_instr", o_instr, m_instr);
            check_val("id_pc", o_pc, m_bpc);
            check_val("id_pc_plus4", id_pc_plus4, m_bpc + 32'd4);
            check_val("id_op", {26'b0, id_op}, {26'b0, m_instr[31:26]});
            check_val("id_funct", {26'b0, id_funct}, {26'b0, m_instr[5:0]});
        end

        fire = exp_req && rdy;
        if (redir) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_bv = 0;
            if (m_busy) begin
                if (rsp) begin m_busy = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else begin
            if (m_bv && idr) m_bv = 0;
            if (fire) begin
                m_busy = 1; m_stale = 0; m_inflight = m_pc;
            end else if (m_busy && rsp) begin
                if (!m_stale) begin
                    m_bv = 1; m_instr = imem_rsp_data; m_bpc = m_inflight;
                    m_pc = m_inflight + 32'd4;
                end
                m_busy = 0; m_stale = 0;
            end
        end

        dut_fire = imem_req_valid && rdy;
        if (dut_fire) issued_q.push_back(imem_addr);
        if (b_imem_req_valid && rdy) b_issued_q.push_back(b_imem_addr);
        if (o_idv) shown_q.push_back(o_pc);
        if (b_id_valid && !b_seen) begin
            b_seen = 1; b_first_pc = b_id_pc; b_first_pc4 = b_id_pc_plus4;
        end

        @(posedge clk);
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (dut_fire) begin
            mem_busy = 1; mem_addr = o_addr;
            mem_cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; imem_rsp_valid = 0; redirect_valid = 0;
        imem_req_ready = 0; id_ready = 0;
        #1;
        check_val("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_val("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check_val("rst_id_instr", id_instr, 32'd0);
        check_val("rst_id_pc", id_pc, 32'd0);
        check_val("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        check_val("rst_imem_addr", imem_addr, 32'd0);
        check_val("rst_wrap_addr", b_imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        mem_busy = 0; mem_cnt = 0; b_seen = 0;
        issued_q.delete(); b_issued_q.delete(); shown_q.delete();
    endtask

    initial begin
        int k;
        bit found;
        model_reset();
        @(negedge clk);

        // Straight-line fetch, both reset PCs
        lat_lo = 1; lat_hi = 1; spur_pct = 0;
        do_reset();
        run_cycle(1, 1, 0, 0, 0);
        check_val("first_req_after_reset", {31'b0, o_req}, 32'd1);
        for (int i = 0; i < 11; i++) run_cycle(1, 1, 0, 0, 0);
        check_val("issued_count", (issued_q.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        check_val("shown_count", (shown_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 4 && i < issued_q.size(); i++)
            check_val("seq_addr", issued_q[i], 32'(4 * i));
        for (int i = 0; i < 3 && i < shown_q.size(); i++)
            check_val("seq_id_pc", shown_q[i], 32'(4 * i));
        check_val("wrap_count", (b_issued_q.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (b_issued_q.size() >= 2) begin
            check_val("wrap_first_req", b_issued_q[0], 32'hFFFF_FFFC);
            check_val("wrap_second_req", b_issued_q[1], 32'h0000_0000);
        end
        check_val("wrap_seen", {31'b0, b_seen}, 32'd1);
        check_val("wrap_first_id_pc", b_first_pc, 32'hFFFF_FFFC);
        check_val("wrap_first_pc_plus4", b_first_pc4, 32'h0000_0000);

        // Decode stall holds the buffer and blocks fetch
        do_reset();
        run_cycle(1, 0, 1, 32'h10, 0);
        check_val("redirect_suppresses_req", {31'b0, o_req}, 32'd0);
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 0, 0, 0, 0);
            check_val("stall_id_valid", {31'b0, o_idv}, 32'd1);
            check_val("stall_id_instr", o_instr, 32'h0000_0020);
            check_val("stall_id_pc", o_pc, 32'h10);
            check_val("stall_no_req", {31'b0, o_req}, 32'd0);
        end
        run_cycle(1, 1, 0, 0, 0);
        check_val("resume_req", {31'b0, o_req}, 32'd1);
        check_val("resume_addr", o_addr, 32'h14);

        // Redirect while waiting for 0x08
        lat_lo = 2; lat_hi = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle(1, 1, 0, 0, 0);
            if (issued_q.size() > 0 && issued_q[issued_q.size()-1] == 32'h8) found = 1;
        end
        check_val("reached_wait_08", {31'b0, found}, 32'd1);
        k = issued_q.size();
        run_cycle(1, 1, 1, 32'h40, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            run_cycle(1, 1, 0, 0, 0);
            if (issued_q.size() > k) found = 1;
        end
        check_val("redirect_req_seen", {31'b0, found}, 32'd1);
        if (found) check_val("redirect_next_addr", issued_q[k], 32'h40);
        for (int i = 0; i < 6; i++) run_cycle(1, 1, 0, 0, 0);
        k = 0;
        foreach (shown_q[i]) if (shown_q[i] == 32'h8) k++;
        check_val("no_id_pc_08", 32'(k), 32'd0);

        // Redirect coinciding with a response
        lat_lo = 1; lat_hi = 1;
        do_reset();
        run_cycle(1, 1, 0, 0, 0);
        run_cycle(1, 1, 1, 32'h43, 0);
        run_cycle(1, 1, 0, 0, 0);
        check_val("coinc_req", {31'b0, o_req}, 32'd1);
        check_val("coinc_addr", o_addr, 32'h40);
        check_val("coinc_id_valid", {31'b0, o_idv}, 32'd0);

        // Reset during WAIT, late response right after release
        do_reset();
        run_cycle(1, 1, 0, 0, 0);
        do_reset();
        run_cycle(1, 1, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            run_cycle(1, 1, 0, 0, 0);
            if (o_idv) found = 1;
        end
        check_val("post_reset_id_valid", {31'b0, found}, 32'd1);
        check_val("post_reset_id_pc", o_pc, 32'h0);
        check_val("post_reset_id_instr", o_instr, mem_word(32'h0));

        // Randomized traffic
        lat_lo = 1; lat_hi = 3; spur_pct = 15;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1000 || i == 2000) begin
                for (int j = 0; j < int'($urandom_range(3)); j++)
                    run_cycle(1, 1, 0, 0, 0);
                do_reset();
            end
            run_cycle($urandom_range(3) != 0, $urandom_range(2) != 0,
                      $urandom_range(11) == 0, $urandom, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL flag a fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-006 imem_addr  output  32  SHALL carry the fetch address.
REQ-007 imem_rsp_valid  input  1  SHALL flag the returned instruction word.
REQ-008 imem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-009 redirect_valid  input  1  SHALL request a PC change from branch or jump resolution.
REQ-010 redirect_pc  input  32  SHALL carry the new fetch address.
REQ-011 id_valid  output  1  SHALL flag a valid instruction for decode.
REQ-012 id_ready  input  1  SHALL flag that decode consumes the instruction this cycle.
REQ-013 id_instr  output  32  SHALL carry the fetched instruction.
REQ-014 id_op  output  6  SHALL equal id_instr[31:26].
REQ-015 id_funct  output  6  SHALL equal id_instr[5:0].
REQ-016 id_pc, id_pc_plus4  output  32 each  SHALL carry the instruction address and that address + 4.

Function
REQ-017 FSM states SHALL be REQ, WAIT and DISCARD, with one outstanding memory request at most.
REQ-018 In REQ, imem_req_valid SHALL be 1 only when the output buffer is empty or is consumed this cycle (id_valid & id_ready); imem_addr = pc.
REQ-019 REQ -> WAIT SHALL occur on imem_req_valid & imem_req_ready; the fetch address SHALL be latched as the in-flight PC.
REQ-020 In WAIT, on imem_rsp_valid the word SHALL load the output buffer (id_valid = 1 next cycle), pc SHALL become in-flight PC + 4, and the FSM SHALL return to REQ.
REQ-021 Minimum latency SHALL be: request accepted cycle N, response N+1, id_valid asserted N+2.
REQ-022 imem_rsp_valid SHALL be ignored in REQ.
REQ-023 The output buffer SHALL hold id_* stable while id_valid & ~id_ready.
REQ-024 The buffer SHALL clear on id_valid & id_ready, unless a response loads it in the same cycle.
REQ-025 redirect_valid SHALL have priority over all other events: pc <= {redirect_pc[31:2], 2'b00}; id_valid <= 0 next cycle.
REQ-026 A redirect in REQ SHALL suppress imem_req_valid that cycle; the FSM SHALL stay in REQ.
REQ-027 A redirect in WAIT without imem_rsp_valid SHALL move the FSM to DISCARD.
REQ-028 A redirect in WAIT coinciding with imem_rsp_valid SHALL drop that response and move the FSM to REQ.
REQ-029 In DISCARD, the next imem_rsp_valid SHALL be dropped and the FSM SHALL go to REQ.
REQ-030 In DISCARD, a further redirect SHALL only update pc.
REQ-031 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-032 id_pc_plus4 SHALL wrap the same way.
REQ-033 imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-034 On rst_n = 0, the block SHALL immediately reset: pc = RESET_PC, FSM = REQ, id_valid = 0, imem_req_valid = 0, id_instr/id_pc/id_pc_plus4 = 0.
REQ-035 A reset during WAIT SHALL abandon the in-flight request; a response arriving after reset release SHALL be ignored, since the FSM is in REQ.
REQ-036 The first request SHALL issue in the first cycle after rst_n deasserts.

Verification
REQ-037 Reset release, memory always ready with 1-cycle response, id_ready = 1: addresses 0,4,8,... SHALL be issued; id_pc SHALL step by 4; id_op and id_funct SHALL match the returned words.
REQ-038 id_ready = 0 for 5 cycles with a buffered word 32'h0000_0020 at pc 0x10: id_* SHALL stay stable, no new request SHALL issue, and fetching SHALL resume the cycle id_ready rises.
REQ-039 Redirect to 0x40 while in WAIT for 0x08: the 0x08 response SHALL be dropped, the next request SHALL be 0x40, and id_pc SHALL never show 0x08.
REQ-040 Redirect to 0x43 coinciding with imem_rsp_valid: the response SHALL be dropped and imem_addr SHALL equal 0x40.
REQ-041 RESET_PC = 32'hFFFF_FFFC: the first id_pc_plus4 SHALL be 0 and the second request SHALL be 0.
REQ-042 rst_n asserted in WAIT with the response one cycle after release: that response SHALL be ignored and the first id_pc SHALL equal RESET_PC.
